carrega_matrizes: RTL and testbench

CARREGA_MATRIZES -- requirements
Module: carrega_matrizes

---
 rtl/carrega_matrizes.sv | 185 ++++++++++++++++++
 tb/tb_carrega_matrizes.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carrega_matrizes.sv
// Loads two N x N matrices (A then B) from one element stream and replays them
// pairwise in row-major order to a downstream adder over a valid/ready handshake.
module carrega_matrizes #(
    parameter int TAMANHO = 5,
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               abort,
    input  logic [LARGURA-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [LARGURA-1:0] out_a,
    output logic [LARGURA-1:0] out_b,
    output logic [2:0]         out_row,
    output logic [2:0]         out_col,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int DEPTH = TAMANHO * TAMANHO;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] MAX_IDX = 3'(TAMANHO - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        EMIT
    } state_t;

    state_t             state_reg;
    logic [2:0]         row_reg;
    logic [2:0]         col_reg;
    logic [AW-1:0]      addr_reg;
    logic               in_ready_reg;
    logic               busy_reg;
    logic               out_valid_reg;
    logic               out_last_reg;
    logic [LARGURA-1:0] out_a_reg;
    logic [LARGURA-1:0] out_b_reg;
    logic [2:0]         out_row_reg;
    logic [2:0]         out_col_reg;

    logic [LARGURA-1:0] mem_a [DEPTH];
    logic [LARGURA-1:0] mem_b [DEPTH];

    logic          in_fire;
    logic          out_fire;
    logic          at_end;
    logic          wr_a;
    logic          wr_b;
    logic [2:0]    row_next;
    logic [2:0]    col_next;
    logic [AW-1:0] addr_next;

    always_comb begin
        in_fire   = in_valid && in_ready_reg;
        out_fire  = out_valid_reg && out_ready;
        at_end    = (row_reg == MAX_IDX) && (col_reg == MAX_IDX);
        wr_a      = in_fire && !abort && (state_reg == LOAD_A);
        wr_b      = in_fire && !abort && (state_reg == LOAD_B);
        addr_next = addr_reg + AW'(1);
        row_next  = row_reg;
        col_next  = col_reg + 3'd1;
        if (col_reg == MAX_IDX) begin
            col_next = 3'd0;
            row_next = row_reg + 3'd1;
        end
    end

    // Storage has no reset so it maps onto block RAM; contents are don't-care after reset/abort.
    always_ff @(posedge clk) begin
        if (wr_a) begin
            mem_a[addr_reg] <= in_data;
        end
        if (wr_b) begin
            mem_b[addr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= LOAD_A;
            row_reg       <= 3'd0;
            col_reg       <= 3'd0;
            addr_reg      <= '0;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_a_reg     <= '0;
            out_b_reg     <= '0;
            out_row_reg   <= 3'd0;
            out_col_reg   <= 3'd0;
        end else if (abort) begin
            state_reg     <= LOAD_A;
            row_reg       <= 3'd0;
            col_reg       <= 3'd0;
            addr_reg      <= '0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                LOAD_A: begin
                    in_ready_reg <= 1'b1;
                    if (in_fire) begin
                        busy_reg <= 1'b1;
                        if (at_end) begin
                            state_reg <= LOAD_B;
                            row_reg   <= 3'd0;
                            col_reg   <= 3'd0;
                            addr_reg  <= '0;
                        end else begin
                            row_reg  <= row_next;
                            col_reg  <= col_next;
                            addr_reg <= addr_next;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_fire) begin
                        if (at_end) begin
                            // Element 0 was written long ago, so the first pair is ready now.
                            state_reg     <= EMIT;
                            in_ready_reg  <= 1'b0;
                            row_reg       <= 3'd0;
                            col_reg       <= 3'd0;
                            addr_reg      <= '0;
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= 1'b0;
                            out_a_reg     <= mem_a[0];
                            out_b_reg     <= mem_b[0];
                            out_row_reg   <= 3'd0;
                            out_col_reg   <= 3'd0;
                        end else begin
                            row_reg  <= row_next;
                            col_reg  <= col_next;
                            addr_reg <= addr_next;
                        end
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (out_last_reg) begin
                            state_reg     <= LOAD_A;
                            row_reg       <= 3'd0;
                            col_reg       <= 3'd0;
                            addr_reg      <= '0;
                            in_ready_reg  <= 1'b1;
                            busy_reg      <= 1'b0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                        end else begin
                            row_reg      <= row_next;
                            col_reg      <= col_next;
                            addr_reg     <= addr_next;
                            out_a_reg    <= mem_a[addr_next];
                            out_b_reg    <= mem_b[addr_next];
                            out_row_reg  <= row_next;
                            out_col_reg  <= col_next;
                            out_last_reg <= (row_next == MAX_IDX) && (col_next == MAX_IDX);
                        end
                    end
                end
                default: begin
                    state_reg <= LOAD_A;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign busy      = busy_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_a     = out_a_reg;
    assign out_b     = out_b_reg;
    assign out_row   = out_row_reg;
    assign out_col   = out_col_reg;

endmodule

// File: tb/tb_carrega_matrizes.sv
// Directed bench for carrega_matrizes with N=5, 8-bit elements.
module tb_carrega_matrizes;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [2:0] out_row;
    logic [2:0] out_col;
    logic       out_last;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;

    int total = 0;
    int bad = 0;

    logic [7:0] ga [25];
    logic [7:0] gb [25];
    logic [2:0] gr [25];
    logic [2:0] gc [25];
    logic       gl [25];

    carrega_matrizes #(.TAMANHO(5), .LARGURA(8)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_a(out_a), .out_b(out_b), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Offer one byte and hold it until accepted; bounded wait on in_ready.
    task automatic push(input logic [7:0] d);
        int g;
        in_data = d;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 50) begin
            total++; bad++;
            $display("FAIL push_timeout in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_seq();
        for (int k = 0; k < 25; k++) push(8'(k));
        for (int k = 0; k < 25; k++) push(8'(8'hFF - k));
    endtask

    // Record every output transfer with out_ready held as set by the caller.
    task automatic collect(output int n);
        n = 0;
        for (int c = 0; c < 300 && n < 25; c++) begin
            if (out_valid && out_ready) begin
                ga[n] = out_a; gb[n] = out_b; gr[n] = out_row; gc[n] = out_col; gl[n] = out_last;
                n++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_last, out_a, out_b, out_row, out_col, busy, in_ready} !== 24'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0",
                     {out_valid, out_last, out_a, out_b, out_row, out_col, busy, in_ready});
        end else $display("reset outputs all zero");
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_early got=%0b required=0", in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_ready_rise in_ready=%0b busy=%0b required 1/0", in_ready, busy);
        end else $display("in_ready high one edge after reset release");
    endtask

    task automatic test_uniform();
        int n;
        for (int k = 0; k < 49; k++) push(8'h04);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL uni_early_valid got=%0b required=0", out_valid);
        end
        push(8'h04);
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL uni_latency valid=%0b ready=%0b busy=%0b required 1/0/1", out_valid, in_ready, busy);
        end
        collect(n);
        total++;
        if (n != 25) begin
            bad++; $display("FAIL uni_count got=%0d required=25", n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ga[k], gb[k], gr[k], gc[k], gl[k]} !== {8'h04, 8'h04, 3'(k / 5), 3'(k % 5), k == 24}) begin
                bad++;
                $display("FAIL uni_pair%0d got a=%h b=%h r=%0d c=%0d l=%0b required 04 04 %0d %0d %0b",
                         k, ga[k], gb[k], gr[k], gc[k], gl[k], k / 5, k % 5, k == 24);
            end else $display("uniform pair %0d (%0d,%0d) a=%h b=%h last=%0b", k, gr[k], gc[k], ga[k], gb[k], gl[k]);
        end
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL uni_return valid=%0b ready=%0b busy=%0b required 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_sequence();
        int n;
        load_seq();
        collect(n);
        total++;
        if (n != 25) begin
            bad++; $display("FAIL seq_count got=%0d required=25", n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ga[k], gb[k], gr[k], gc[k], gl[k]} !== {8'(k), 8'(8'hFF - k), 3'(k / 5), 3'(k % 5), k == 24}) begin
                bad++;
                $display("FAIL seq_pair%0d got a=%h b=%h r=%0d c=%0d l=%0b", k, ga[k], gb[k], gr[k], gc[k], gl[k]);
            end else $display("seq pair %0d (%0d,%0d) a=%h b=%h", k, gr[k], gc[k], ga[k], gb[k]);
        end
    endtask

    task automatic test_stall();
        int n;
        bit stalled;
        load_seq();
        n = 0;
        stalled = 0;
        for (int c = 0; c < 300 && n < 25; c++) begin
            if (out_valid && !stalled && out_row == 3'd2 && out_col == 3'd3) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk); #1;
                    total++;
                    if ({out_valid, in_ready, out_a, out_b, out_row, out_col, out_last} !==
                        {1'b1, 1'b0, 8'd13, 8'hF2, 3'd2, 3'd3, 1'b0}) begin
                        bad++;
                        $display("FAIL stall_hold%0d got v=%0b r=%0b a=%h b=%h (%0d,%0d) l=%0b required 1 0 0d f2 (2,3) 0",
                                 s, out_valid, in_ready, out_a, out_b, out_row, out_col, out_last);
                    end else $display("stall cycle %0d bundle held", s);
                end
                out_ready = 1'b1;
                stalled = 1;
            end
            if (out_valid && out_ready) begin
                ga[n] = out_a; gb[n] = out_b; gr[n] = out_row; gc[n] = out_col; gl[n] = out_last;
                n++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (n != 25 || !stalled) begin
            bad++; $display("FAIL stall_count got=%0d stalled=%0b required 25/1", n, stalled);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ga[k], gb[k], gr[k], gc[k], gl[k]} !== {8'(k), 8'(8'hFF - k), 3'(k / 5), 3'(k % 5), k == 24}) begin
                bad++;
                $display("FAIL stall_pair%0d got a=%h b=%h r=%0d c=%0d l=%0b", k, ga[k], gb[k], gr[k], gc[k], gl[k]);
            end else $display("stall pair %0d (%0d,%0d) a=%h b=%h", k, gr[k], gc[k], ga[k], gb[k]);
        end
    endtask

    task automatic test_gaps();
        int n;
        bit first;
        first = 1;
        for (int k = 0; k < 50; k++) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                @(posedge clk); #1;
            end
            if (first) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++; $display("FAIL gap_busy_idle got=%0b required=0", busy);
                end
            end
            push(k < 25 ? 8'(k) : 8'(8'hFF - (k - 25)));
            if (first) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL gap_busy_rise got=%0b required=1", busy);
                end else $display("busy high after first accepted byte");
                first = 0;
            end
        end
        collect(n);
        total++;
        if (n != 25) begin
            bad++; $display("FAIL gap_count got=%0d required=25", n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ga[k], gb[k], gr[k], gc[k], gl[k]} !== {8'(k), 8'(8'hFF - k), 3'(k / 5), 3'(k % 5), k == 24}) begin
                bad++;
                $display("FAIL gap_pair%0d got a=%h b=%h r=%0d c=%0d l=%0b", k, ga[k], gb[k], gr[k], gc[k], gl[k]);
            end else $display("gap pair %0d (%0d,%0d) a=%h b=%h", k, gr[k], gc[k], ga[k], gb[k]);
        end
    endtask

    task automatic test_rst_reload();
        int n;
        for (int k = 0; k < 30; k++) push(8'h55);
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            bad++; $display("FAIL rst_mid got v/busy/ready=%b required 000", {out_valid, busy, in_ready});
        end else $display("mid-load reset cleared status");
        @(posedge clk); #1;
        rst = 1'b0;
        load_seq();
        collect(n);
        total++;
        if (n != 25) begin
            bad++; $display("FAIL rst_count got=%0d required=25", n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ga[k], gb[k], gr[k], gc[k], gl[k]} !== {8'(k), 8'(8'hFF - k), 3'(k / 5), 3'(k % 5), k == 24}) begin
                bad++;
                $display("FAIL rst_pair%0d got a=%h b=%h r=%0d c=%0d l=%0b", k, ga[k], gb[k], gr[k], gc[k], gl[k]);
            end else $display("reload pair %0d (%0d,%0d) a=%h b=%h", k, gr[k], gc[k], ga[k], gb[k]);
        end
    endtask

    task automatic test_abort();
        int n;
        for (int k = 0; k < 9; k++) push(8'hAA);
        in_data = 8'h77;
        in_valid = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_status ready=%0b busy=%0b required 1/0", in_ready, busy);
        end else $display("abort returned to idle load");
        load_seq();
        collect(n);
        total++;
        if (n != 25) begin
            bad++; $display("FAIL abort_count got=%0d required=25", n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ga[k], gb[k], gr[k], gc[k], gl[k]} !== {8'(k), 8'(8'hFF - k), 3'(k / 5), 3'(k % 5), k == 24}) begin
                bad++;
                $display("FAIL abort_pair%0d got a=%h b=%h r=%0d c=%0d l=%0b", k, ga[k], gb[k], gr[k], gc[k], gl[k]);
            end else $display("post-abort pair %0d (%0d,%0d) a=%h b=%h", k, gr[k], gc[k], ga[k], gb[k]);
        end
    endtask

    // A byte offered during EMIT must wait and become A[0][0] of the next load.
    task automatic test_back_to_back();
        int n;
        load_seq();
        in_data = 8'h99;
        in_valid = 1'b1;
        collect(n);
        total++;
        if (n != 25 || in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_emit count=%0d ready=%0b required 25/1", n, in_ready);
        end
        push(8'h99);
        for (int k = 1; k < 25; k++) push(8'(k));
        for (int k = 0; k < 25; k++) push(8'(8'hFF - k));
        collect(n);
        total++;
        if (n != 25) begin
            bad++; $display("FAIL b2b_count got=%0d required=25", n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if ({ga[k], gb[k], gr[k], gc[k], gl[k]} !==
                {(k == 0) ? 8'h99 : 8'(k), 8'(8'hFF - k), 3'(k / 5), 3'(k % 5), k == 24}) begin
                bad++;
                $display("FAIL b2b_pair%0d got a=%h b=%h r=%0d c=%0d l=%0b", k, ga[k], gb[k], gr[k], gc[k], gl[k]);
            end else $display("b2b pair %0d (%0d,%0d) a=%h b=%h", k, gr[k], gc[k], ga[k], gb[k]);
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_sequence();
        test_stall();
        test_gaps();
        test_rst_reload();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
